instr_issue_queue: RTL and testbench
====================================

Name: instr_issue_queue

Overview:
- In-order instruction queue between the fetch stage and the decode/issue stage of the Tomasulo core.
- Buffers fetched instruction words with their PCs.
- Presents the oldest entry to the combinational decoder, which produces Op/ALUControl for reservation-station dispatch.
- Decouples fetch from issue stalls when reservation stations are full; supports a single-cycle flush on branch/jal redirect.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- XLEN, 32, width of instruction word and PC.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents an instruction this cycle.
- in_ready  output  1  queue can accept; equals !full.
- in_instr  input  XLEN  fetched instruction word.
- in_pc  input  XLEN  PC of in_instr.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  issue accepts the head this cycle (reservation station free).
- out_instr  output  XLEN  head instruction word, driven to the decoder.
- out_pc  output  XLEN  head PC.
- flush  input  1  discard all entries (redirect).
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries {instr, pc}.
  - Read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits; wrap modulo DEPTH.
  - count is a registered occupancy counter.
  - full = (count == DEPTH); empty = (count == 0).
- Push = in_valid & in_ready. Writes entry[wr_ptr] and advances wr_ptr.
- Pop = out_valid & out_ready. Advances rd_ptr.
- Outputs:
  - out_instr/out_pc are driven combinationally from entry[rd_ptr].
  - When empty they hold 0 (not the stale entry), so the decoder sees opcode 0 and produces its default controls.
- Latency and bypass:
  - A push into an empty queue appears on out_* on the next cycle; no same-cycle fall-through.
  - in_ready depends only on registered state, never on out_ready. A push and pop in the same cycle while full is not possible; in_ready = 0 when full.
- Simultaneous push and pop (not full, not empty): both pointers advance and count is unchanged.
- out_ready while empty: no effect, no underflow. in_valid while full: no effect, no overwrite. Fetch must hold in_instr/in_pc stable until accepted.
- Flush:
  - Sampled at posedge. Sets rd_ptr = wr_ptr = 0 and count = 0.
  - Any push or pop in the same cycle is discarded; flush has priority over both.
  - in_ready and out_valid are not masked during the flush cycle, but their effects are nullified.
  - The next cycle is empty with in_ready = 1.
- Reset (synchronous, priority over flush):
  - Pointers and count go to 0; out_valid = 0; in_ready = 1; out_instr = out_pc = 0.
  - Storage contents need not be cleared.
  - Reset asserted mid-stream drops all entries on that edge.
- count update: count_next = count + push - pop, computed in CNT_W bits. It must reach exactly DEPTH when full.
- No combinational path from in_* to out_*.

Test Plan:
- Reset then idle: assert reset 2 cycles -> out_valid = 0, in_ready = 1, count = 0, out_instr = 0x00000000.
- Single push: push instr 0x00500093 / pc 0x00000000 -> next cycle out_valid = 1, out_instr = 0x00500093, out_pc = 0, count = 1. Pop with out_ready = 1 -> next cycle out_valid = 0.
- Fill and wrap:
  - Push 8 instrs (pc 0x0..0x1C) with out_ready = 0 -> count = 8, in_ready = 0; a 9th in_valid is ignored.
  - Pop 3, push 3 (pc 0x20..0x28) -> pops return pc 0x0, 0x4, 0x8 in order.
  - Drain -> pcs 0xC..0x28 in order, count returns to 0.
- Simultaneous push/pop at count = 4: in_valid = out_ready = 1 for 5 cycles -> count stays 4 and output order is strictly FIFO.
- Flush with a concurrent push and pop at count = 5 -> next cycle count = 0, out_valid = 0, in_ready = 1; the pushed instruction never appears at the output.
- Reset mid-stream at count = 6 with in_valid = 1 -> next cycle count = 0. The subsequent push of 0x00000063 (beq) is the first item out.

Source files
------------

// File: rtl/instr_issue_queue.sv
// In-order instruction queue between fetch and decode/issue.
// Circular buffer of {instr, pc} entries; the head is presented to the
// combinational decoder and is forced to zero while the queue is empty.
module instr_issue_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  // Entry storage; no reset needed since occupancy gates every read.
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Handshake status comes from registered occupancy only, so in_ready
  // never depends on out_ready and no in_* to out_* path exists.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  // Head entry to the decoder; zero when empty so it sees opcode 0.
  assign out_instr = empty ? '0 : instr_mem[rd_ptr_q];
  assign out_pc    = empty ? '0 : pc_mem[rd_ptr_q];

  // Next-state for pointers and occupancy; flush discards any push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointer/occupancy registers; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the accepted instruction into the tail slot.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed self-checking bench for instr_issue_queue.
module tb_instr_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        flush;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  instr_issue_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] epc;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;
    #1;

    // Reset for two cycles, then idle state
    step(); step();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_instr", out_instr,      32'h0);
    chk("rst_out_pc",    out_pc,         32'h0);
    $display("reset: out_valid=%0d in_ready=%0d count=%0d", out_valid, in_ready, count);

    // Single push, visible next cycle
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_instr", out_instr,      32'h00500093);
    chk("single_pc",    out_pc,         32'h0);
    chk("single_count", 32'(count),     32'd1);
    $display("push: instr=%h pc=%h count=%0d", out_instr, out_pc, count);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_pop_valid", 32'(out_valid), 32'd0);
    chk("single_pop_instr", out_instr,      32'h0);
    $display("pop: out_valid=%0d", out_valid);

    // Fill 8 entries with pc 0x0..0x1C
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = 32'h10000000 + 32'(i); in_pc = 32'(i * 4);
      step();
    end
    chk("fill_count",    32'(count),    32'd8);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_head_pc",  out_pc,        32'h0);
    // 9th offer must be ignored
    in_instr = 32'hDEADBEEF; in_pc = 32'h99;
    step();
    in_valid = 1'b0;
    chk("ovf_count",   32'(count), 32'd8);
    chk("ovf_head_pc", out_pc,     32'h0);
    $display("fill: count=%0d in_ready=%0d", count, in_ready);

    // Pop 3 -> pc 0x0, 0x4, 0x8
    for (int k = 0; k < 3; k++) begin
      chk("pop3_pc",    out_pc,    32'(k * 4));
      chk("pop3_instr", out_instr, 32'h10000000 + 32'(k));
      $display("pop: pc=%h instr=%h", out_pc, out_instr);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk("pop3_count", 32'(count), 32'd5);

    // Push 3 more (pc 0x20..0x28), wrapping the tail
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_instr = 32'h20000000 + 32'(k); in_pc = 32'h20 + 32'(k * 4);
      step();
    end
    in_valid = 1'b0;
    chk("wrap_count", 32'(count), 32'd8);

    // Drain: pc 0xC..0x28 in order
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      epc = 32'hC + 32'(k * 4);
      chk("drain_pc", out_pc, epc);
      chk("drain_instr", out_instr,
          (epc < 32'h20) ? (32'h10000000 + (epc >> 2)) : (32'h20000000 + ((epc - 32'h20) >> 2)));
      $display("drain: pc=%h instr=%h", out_pc, out_instr);
      step();
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count),     32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Build count=4 (pc 0x100..0x10C)
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'h30000000 + 32'(i); in_pc = 32'h100 + 32'(i * 4);
      step();
    end
    chk("sim_pre_count", 32'(count), 32'd4);
    // Simultaneous push/pop for 5 cycles
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_instr = 32'h30000004 + 32'(j); in_pc = 32'h110 + 32'(j * 4);
      chk("sim_head_pc", out_pc, 32'h100 + 32'(j * 4));
      step();
      chk("sim_count", 32'(count), 32'd4);
      $display("pushpop: head_pc=%h count=%0d", out_pc, count);
    end
    in_valid = 1'b0;
    // Remaining: pc 0x114..0x120
    for (int k = 0; k < 4; k++) begin
      epc = 32'h114 + 32'(k * 4);
      chk("sim_drain_pc",    out_pc,    epc);
      chk("sim_drain_instr", out_instr, 32'h30000000 + ((epc - 32'h100) >> 2));
      step();
    end
    out_ready = 1'b0;
    chk("sim_drain_count", 32'(count), 32'd0);

    // Flush at count=5 with concurrent push and pop
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = 32'h40000000 + 32'(i); in_pc = 32'h200 + 32'(i * 4);
      step();
    end
    chk("fl_pre_count", 32'(count), 32'd5);
    in_valid = 1'b1; in_instr = 32'h0BADC0DE; in_pc = 32'h300;
    out_ready = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    chk("fl_count",    32'(count),     32'd0);
    chk("fl_valid",    32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready),  32'd1);
    chk("fl_instr",    out_instr,      32'h0);
    $display("flush: count=%0d out_valid=%0d in_ready=%0d", count, out_valid, in_ready);
    step();
    chk("fl_idle_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    chk("fl_next_instr", out_instr,  32'h00000013);
    chk("fl_next_pc",    out_pc,     32'h400);
    chk("fl_next_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fl_empty", 32'(count), 32'd0);

    // Reset mid-stream at count=6 with in_valid asserted
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_instr = 32'h50000000 + 32'(i); in_pc = 32'h500 + 32'(i * 4);
      step();
    end
    chk("mr_pre_count", 32'(count), 32'd6);
    reset = 1'b1; in_instr = 32'h11111111; in_pc = 32'h580;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("mr_count", 32'(count),     32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_instr", out_instr,      32'h0);
    $display("midreset: count=%0d out_valid=%0d", count, out_valid);
    in_valid = 1'b1; in_instr = 32'h00000063; in_pc = 32'h600;
    step();
    in_valid = 1'b0;
    chk("mr_beq_valid", 32'(out_valid), 32'd1);
    chk("mr_beq_instr", out_instr,      32'h00000063);
    chk("mr_beq_pc",    out_pc,         32'h600);
    chk("mr_beq_count", 32'(count),     32'd1);
    $display("beq: instr=%h pc=%h", out_instr, out_pc);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("mr_final_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
